// File: rtl/channel_deinterleave_4.sv
// channel_deinterleave_4: regroups a serial c0..c3 channel stream into aligned 4-channel pixels
// with a valid/ready handshake on both sides and a frame-last flag.
module channel_deinterleave_4 #(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Datawidth-1:0] In,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [Datawidth-1:0] Out_0,
  output logic [Datawidth-1:0] Out_1,
  output logic [Datawidth-1:0] Out_2,
  output logic [Datawidth-1:0] Out_3,
  output logic                 valid_out,
  input  logic                 out_ready,
  output logic                 frame_last
);
  localparam int PIX = IMG_Width * IMG_Height;
  localparam int CW  = (PIX > 1) ? $clog2(PIX) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t               state_q;
  logic [1:0]           lane_q;
  logic [CW-1:0]        pix_cnt_q;
  logic [Datawidth-1:0] s0_q, s1_q, s2_q;
  assign ready_in = (state_q == FILL) & rst;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FILL;
      lane_q     <= '0;
      pix_cnt_q  <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      Out_0      <= '0;
      Out_1      <= '0;
      Out_2      <= '0;
      Out_3      <= '0;
      valid_out  <= 1'b0;
      frame_last <= 1'b0;
    end else if (state_q == FILL) begin
      if (valid_in) begin
        lane_q <= lane_q + 2'd1;
        if (lane_q == 2'd0) s0_q <= In;
        if (lane_q == 2'd1) s1_q <= In;
        if (lane_q == 2'd2) s2_q <= In;
        if (lane_q == 2'd3) begin
          Out_0      <= s0_q;
          Out_1      <= s1_q;
          Out_2      <= s2_q;
          Out_3      <= In;
          valid_out  <= 1'b1;
          frame_last <= (pix_cnt_q == CW'(PIX - 1));
          state_q    <= FULL;
        end
      end
    end else if (out_ready) begin
      // frame_last already encodes "pix_cnt is the final pixel", so it drives the wrap
      valid_out  <= 1'b0;
      frame_last <= 1'b0;
      state_q    <= FILL;
      pix_cnt_q  <= frame_last ? '0 : pix_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_channel_deinterleave_4.sv
// tb_channel_deinterleave_4: randomized and directed checks against a queue-based pixel model.
module tb_channel_deinterleave_4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_w = '0;
  logic        valid_in = 1'b0;
  logic        out_ready = 1'b1;
  logic        ready_in, valid_out, frame_last;
  logic [31:0] out_0, out_1, out_2, out_3;
  channel_deinterleave_4 #(.IMG_Width(3), .IMG_Height(3), .Datawidth(32)) dut (
    .clk(clk), .rst(rst), .In(in_w), .valid_in(valid_in), .ready_in(ready_in),
    .Out_0(out_0), .Out_1(out_1), .Out_2(out_2), .Out_3(out_3),
    .valid_out(valid_out), .out_ready(out_ready), .frame_last(frame_last)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0][31:0] w; logic last;} pix_t;
  logic [31:0]      part[$];
  pix_t             pend[$];
  logic [3:0][31:0] shown = '0;
  int               npix = 0;
  int               n_cmp = 0, n_bad = 0;
  int               dut_pulses = 0, dut_lasts = 0;
  bit               accepted;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // advance the reference model by one clock using the inputs held across the edge
  task automatic model_step();
    accepted = 1'b0;
    if (!rst) begin
      part.delete();
      pend.delete();
      shown = '0;
      npix  = 0;
    end else if (pend.size() != 0) begin
      if (out_ready) begin
        void'(pend.pop_front());
        npix = (npix + 1) % 9;
      end
    end else if (valid_in) begin
      pix_t p;
      accepted = 1'b1;
      part.push_back(in_w);
      if (part.size() == 4) begin
        p.w    = {part[3], part[2], part[1], part[0]};
        p.last = (npix == 8);
        pend.push_back(p);
        shown  = p.w;
        part.delete();
      end
    end
  endtask
  task automatic cyc();
    if (rst && valid_out && out_ready) begin
      dut_pulses++;
      if (frame_last) dut_lasts++;
    end
    model_step();
    @(posedge clk);
    #1;
    chk("valid_out", {31'd0, valid_out}, {31'd0, pend.size() != 0});
    chk("frame_last", {31'd0, frame_last}, {31'd0, (pend.size() != 0) && pend[0].last});
    chk("ready_in", {31'd0, ready_in}, {31'd0, rst && pend.size() == 0});
    chk("out_0", out_0, shown[0]);
    chk("out_1", out_1, shown[1]);
    chk("out_2", out_2, shown[2]);
    chk("out_3", out_3, shown[3]);
  endtask
  task automatic push(input logic [31:0] word);
    int tries;
    valid_in = 1'b1;
    in_w     = word;
    for (tries = 0; tries < 50; tries++) begin
      cyc();
      if (accepted) break;
    end
    if (tries == 50) chk("push_timeout", 32'(tries), 32'd0);
  endtask
  initial begin
    // T1: reset held with valid_in high
    valid_in = 1'b1;
    in_w     = 32'd99;
    repeat (3) cyc();
    rst      = 1'b1;
    valid_in = 1'b0;
    // T2: single pixel, back to back
    push(32'd10); push(32'd20); push(32'd30); push(32'd40);
    valid_in = 1'b0;
    chk("t2_out0", out_0, 32'd10);
    chk("t2_out3", out_3, 32'd40);
    repeat (2) cyc();
    // T3: full 3x3 frame after a fresh reset
    rst = 1'b0; cyc(); rst = 1'b1;
    dut_pulses = 0; dut_lasts = 0;
    for (int k = 0; k < 36; k++) push(32'(k));
    valid_in = 1'b0;
    chk("t3_last_out0", out_0, 32'd32);
    chk("t3_last_out3", out_3, 32'd35);
    chk("t3_last_flag", {31'd0, frame_last}, 32'd1);
    repeat (3) cyc();
    chk("t3_pulses", 32'(dut_pulses), 32'd9);
    chk("t3_lasts", 32'(dut_lasts), 32'd1);
    // T4: backpressure for 6 cycles with a word waiting
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(32'h200 + 32'(k));
    in_w = 32'h300;
    repeat (6) cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h300 + 32'(k));
    valid_in = 1'b0;
    chk("t4_out0", out_0, 32'h300);
    repeat (2) cyc();
    // T5: bubbles in valid_in
    begin
      logic [6:0]  vpat = 7'b1011001;
      logic [31:0] dseq[7] = '{5, 0, 0, 6, 7, 0, 8};
      for (int k = 0; k < 7; k++) begin
        valid_in = vpat[k];
        in_w     = dseq[k];
        cyc();
      end
    end
    valid_in = 1'b0;
    chk("t5_out1", out_1, 32'd6);
    chk("t5_out3", out_3, 32'd8);
    repeat (2) cyc();
    // T6: reset in the middle of a pixel
    push(32'hAA); push(32'hBB);
    valid_in = 1'b0;
    rst = 1'b0; cyc(); rst = 1'b1;
    dut_pulses = 0; dut_lasts = 0;
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    valid_in = 1'b0;
    chk("t6_out0", out_0, 32'd1);
    chk("t6_out3", out_3, 32'd4);
    for (int k = 0; k < 32; k++) push($urandom);
    valid_in = 1'b0;
    repeat (3) cyc();
    chk("t6_pulses", 32'(dut_pulses), 32'd9);
    chk("t6_lasts", 32'(dut_lasts), 32'd1);
    // randomized traffic with occasional resets and backpressure
    for (int k = 0; k < 3000; k++) begin
      valid_in  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_w      = $urandom;
      rst       = ($urandom % 250) != 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
